// File: rtl/weight_skew_fifo.sv
`default_nettype none
//==============================================================================
// Module   : weight_skew_fifo
// Brief    : Tile-sized weight staging FIFO with valid/ready fill, lane masking
//            and diagonally skewed drain into the systolic array top edge.
//            Optional build macro: WEIGHT_SKEW_FIFO_RECIRC_EN (tile replay).
// Revision : 1.0 - initial release
//==============================================================================
module weight_skew_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              w_in [0:FIFO_WIDTH-1],
    input  logic [FIFO_WIDTH-1:0]              lane_mask,
    input  logic                               drain_start,
    output logic [DATA_WIDTH-1:0]              w_out [0:FIFO_WIDTH-1],
    output logic [FIFO_WIDTH-1:0]              out_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               busy,
    output logic                               tile_done
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cyc_w = $clog2(FIFO_DEPTH + FIFO_WIDTH);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FIFO_DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [c_cyc_w-1:0] c_pop_lim  = c_cyc_w'(FIFO_DEPTH);
    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(FIFO_DEPTH + FIFO_WIDTH - 1);

`ifdef WEIGHT_SKEW_FIFO_RECIRC_EN
    localparam bit c_recirc = 1'b1;
`else
    localparam bit c_recirc = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [c_ptr_w-1:0]   rd_q,    rd_d;
    logic [c_cyc_w-1:0]   cyc_q,   cyc_d;
    logic                 w_accept;
    logic                 w_pop;

    logic [DATA_WIDTH-1:0] mem_q   [0:FIFO_DEPTH-1][0:FIFO_WIDTH-1];
    logic [DATA_WIDTH-1:0] pop_row [0:FIFO_WIDTH-1];

    // cyc_q numbers the drain cycles 1..c_cyc_last; rows are popped in 0..DEPTH-1
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_d      = rd_q;
        cyc_d     = '0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        tile_done = 1'b0;
        w_accept  = 1'b0;
        w_pop     = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    count_d  = count_q + 1'b1;
                    if (count_q == c_cnt_last) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (drain_start) begin
                    w_pop   = 1'b1;
                    cyc_d   = c_cyc_w'(1);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy  = 1'b1;
                cyc_d = cyc_q + 1'b1;
                if (cyc_q < c_pop_lim) begin
                    w_pop = 1'b1;
                end
                if (cyc_q == c_cyc_last) begin
                    tile_done = 1'b1;
                    cyc_d     = '0;
                    state_d   = c_recirc ? S_FULL : S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        if (w_pop) begin
            rd_d = (rd_q == c_ptr_last) ? '0 : rd_q + 1'b1;
            if (!c_recirc) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_FILL;
            count_q <= '0;
            rd_q    <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            cyc_q   <= cyc_d;
        end
    end

    // With recirculation the tile is full, so the tail slot is the one just
    // read: rewriting the popped row there leaves the storage unchanged.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < FIFO_DEPTH; r++) begin
                for (int j = 0; j < FIFO_WIDTH; j++) begin
                    mem_q[r][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int j = 0; j < FIFO_WIDTH; j++) begin
                mem_q[count_q[c_ptr_w-1:0]][j] <= lane_mask[j] ? w_in[j] : '0;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < FIFO_WIDTH; j++) begin
            pop_row[j] = w_pop ? mem_q[rd_q][j] : '0;
        end
    end

    // Lane j: j skew stages plus the output register; zeros flow when idle
    for (genvar j = 0; j < FIFO_WIDTH; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] dly_q [0:j];
        logic [j:0]            vld_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int k = 0; k <= j; k++) begin
                    dly_q[k] <= '0;
                end
                vld_q <= '0;
            end else begin
                dly_q[0] <= pop_row[j];
                vld_q[0] <= w_pop;
                for (int k = 1; k <= j; k++) begin
                    dly_q[k] <= dly_q[k-1];
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end

        assign w_out[j]     = dly_q[j];
        assign out_valid[j] = vld_q[j];
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_skew_fifo.sv
`default_nettype none
//==============================================================================
// Module   : tb_weight_skew_fifo
// Brief    : Directed, table-driven bench for weight_skew_fifo (4x4 tile).
// Revision : 1.0 - initial release
//==============================================================================
module tb_weight_skew_fifo;

    localparam int DW = 16;
    localparam int FW = 4;
    localparam int FD = 4;

`ifdef WEIGHT_SKEW_FIFO_RECIRC_EN
    localparam bit RECIRC = 1'b1;
`else
    localparam bit RECIRC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] w_in  [0:FW-1];
    logic [FW-1:0] lane_mask;
    logic          drain_start;
    logic [DW-1:0] w_out [0:FW-1];
    logic [FW-1:0] out_valid;
    logic [2:0]    count;
    logic          busy;
    logic          tile_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    weight_skew_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_WIDTH (FW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .w_in        (w_in),
        .lane_mask   (lane_mask),
        .drain_start (drain_start),
        .w_out       (w_out),
        .out_valid   (out_valid),
        .count       (count),
        .busy        (busy),
        .tile_done   (tile_done)
    );

    typedef struct {
        logic        rstn;
        logic        iv;
        logic        ds;
        logic [3:0]  mask;
        logic [63:0] win;
        logic        e_ready;
        logic [2:0]  e_cnt;
        logic [3:0]  e_ov;
        logic        e_busy;
        logic        e_td;
        logic [63:0] e_wout;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [63:0] row_of(input int r);
        logic [63:0] v;
        for (int j = 0; j < FW; j++) v[16*j +: 16] = 16'(16*r + j);
        return v;
    endfunction

    function automatic logic [63:0] wout_p();
        logic [63:0] v;
        for (int j = 0; j < FW; j++) v[16*j +: 16] = w_out[j];
        return v;
    endfunction

    task automatic set_row(input logic [63:0] v);
        for (int j = 0; j < FW; j++) w_in[j] = v[16*j +: 16];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic e_ready, input logic [2:0] e_cnt,
                               input logic [3:0] e_ov, input logic e_busy, input logic e_td,
                               input logic [63:0] e_wout);
        chk({tag, " in_ready"},  64'(in_ready),  64'(e_ready));
        chk({tag, " count"},     64'(count),     64'(e_cnt));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, " busy"},      64'(busy),      64'(e_busy));
        chk({tag, " tile_done"}, 64'(tile_done), 64'(e_td));
        chk({tag, " w_out"},     wout_p(),       e_wout);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0; in_valid = 1'b0; drain_start = 1'b0;
        tick();
        tick();
        check_state(tag, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 64'h0);
        rstn = 1'b1;
    endtask

    task automatic fill4(input string tag, input logic [63:0] rows [4], input logic [3:0] masks [4]);
        for (int r = 0; r < FD; r++) begin
            in_valid = 1'b1; set_row(rows[r]); lane_mask = masks[r];
            tick();
            chk($sformatf("%s fill%0d count", tag, r), 64'(count), 64'(r + 1));
            chk($sformatf("%s fill%0d in_ready", tag, r), 64'(in_ready), 64'(r < FD - 1));
        end
        in_valid = 1'b0; lane_mask = 4'hF;
    endtask

    // Row r reaches lane j in drain cycle c = 1 + r + j
    task automatic drain_check(input string tag, input logic [63:0] rows [4]);
        logic [63:0] e_w;
        logic [3:0]  e_ov;
        logic [2:0]  e_cnt;
        int          r;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int c = 1; c <= FD + FW - 1; c++) begin
            if (c > 1) tick();
            e_w = '0; e_ov = '0;
            for (int j = 0; j < FW; j++) begin
                r = c - 1 - j;
                if (r >= 0 && r < FD) begin
                    e_ov[j] = 1'b1;
                    e_w[16*j +: 16] = rows[r][16*j +: 16];
                end
            end
            e_cnt = RECIRC ? 3'd4 : ((c <= FD) ? 3'(FD - c) : 3'd0);
            check_state($sformatf("%s c%0d", tag, c), 1'b0, e_cnt, e_ov, 1'b1, c == FD + FW - 1, e_w);
        end
        tick();
        check_state({tag, " end"}, !RECIRC, RECIRC ? 3'd4 : 3'd0, 4'h0, 1'b0, 1'b0, 64'h0);
    endtask

    logic [63:0] rows  [4];
    logic [63:0] exp_r [4];
    logic [3:0]  masks [4];

    initial begin
        rstn = 1'b0; in_valid = 1'b0; drain_start = 1'b0; lane_mask = 4'hF;
        set_row(64'h0);

        tbl[0] = '{1'b0, 1'b0, 1'b0, 4'hF, 64'h0,      1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'hF, row_of(9),  1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 4'hF, row_of(0),  1'b1, 3'd1, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'hF, row_of(1),  1'b1, 3'd2, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'hF, row_of(2),  1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4'hF, row_of(3),  1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 4'hF, row_of(4),  1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 64'h0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 4'hF, row_of(5),  1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 64'h0};

        for (int i = 0; i < 8; i++) begin
            rstn = tbl[i].rstn; in_valid = tbl[i].iv; drain_start = tbl[i].ds;
            lane_mask = tbl[i].mask; set_row(tbl[i].win);
            tick();
            check_state($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_cnt, tbl[i].e_ov,
                        tbl[i].e_busy, tbl[i].e_td, tbl[i].e_wout);
        end
        in_valid = 1'b0;

        // Tile rows 0..3 loaded by the table; the 5th and 6th rows were refused
        for (int r = 0; r < FD; r++) rows[r] = row_of(r);
        drain_check("drain1", rows);
        if (RECIRC) drain_check("drain2", rows);

        // Lane mask: row 0 keeps only lanes 0 and 2
        do_reset("rst_mask");
        for (int r = 0; r < FD; r++) begin
            rows[r] = row_of(r); exp_r[r] = row_of(r); masks[r] = 4'hF;
        end
        rows[0]  = {4{16'hABCD}};
        masks[0] = 4'b0101;
        exp_r[0] = 64'h0000_ABCD_0000_ABCD;
        fill4("mask", rows, masks);
        drain_check("mask_drain", exp_r);

        // Reset in the middle of a drain, then a fresh tile
        do_reset("rst_mid");
        for (int r = 0; r < FD; r++) begin
            rows[r] = row_of(r + 4); masks[r] = 4'hF;
        end
        fill4("mid", rows, masks);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("mid c1 out_valid", 64'(out_valid), 64'h1);
        tick();
        tick();
        chk("mid c3 out_valid", 64'(out_valid), 64'h7);
        rstn = 1'b0;
        tick();
        check_state("mid abort", 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 64'h0);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_state($sformatf("mid idle%0d", k), 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 64'h0);
        end
        for (int r = 0; r < FD; r++) rows[r] = row_of(r + 8);
        fill4("refill", rows, masks);
        drain_check("refill_drain", rows);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_skew_fifo.md
Name: weight_skew_fifo

Overview:
- Next-generation weight staging buffer for the systolic array; sits between the weight SRAM reader and the top edge of the PE array.
- Accepts one row of FIFO_WIDTH lane weights per handshake until a tile of FIFO_DEPTH rows is held.
- On command, drains the tile in arrival order with diagonal skew: lane j is delayed j cycles so weights enter PE columns wavefront-aligned.
- Adds over the plain enable-shift array: valid/ready fill, occupancy count, zero-padding lane mask, skewed drain and per-lane valids.

Parameters:
DATA_WIDTH, 16, bits per weight
FIFO_WIDTH, 16, number of lanes (PE columns), >=1
FIFO_DEPTH, 16, rows per tile, >=2

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  row on w_in is valid
in_ready  output  1  block can accept a row
w_in  input  DATA_WIDTH x FIFO_WIDTH (unpacked [0:FIFO_WIDTH-1])  incoming row
lane_mask  input  FIFO_WIDTH  sampled with row; bit j=0 stores zero for lane j
drain_start  input  1  single-cycle request to begin drain
w_out  output  DATA_WIDTH x FIFO_WIDTH (unpacked)  skewed output weights, registered
out_valid  output  FIFO_WIDTH  per-lane valid for w_out[j]
count  output  $clog2(FIFO_DEPTH+1)  rows currently held
busy  output  1  high in DRAIN
tile_done  output  1  one-cycle pulse on final drain output cycle

Behaviour:
- Reset: rstn sampled low at an edge -> state FILL, count=0, in_ready=1, w_out all 0, out_valid=0, busy=0, tile_done=0, all storage and skew stages cleared. Reset mid-fill or mid-drain aborts immediately; no partial output after reset.
- States: FILL, FULL, DRAIN.
- FILL: in_ready=1. A row is accepted when in_valid&&in_ready; stored value per lane = lane_mask[j] ? w_in[j] : 0. count increments by 1. The acceptance that makes count==FIFO_DEPTH moves to FULL on the same edge. drain_start ignored.
- FULL: in_ready=0; in_valid ignored. drain_start=1 at edge t -> DRAIN from t+1.
- DRAIN: in_ready=0, busy=1. Row r (0 = oldest) appears on lane j at cycle t+1+r+j with out_valid[j]=1. Otherwise out_valid[j]=0 and w_out[j]=0. count decrements once per row popped from lane 0 (t+1..t+FIFO_DEPTH).
- DRAIN lasts FIFO_DEPTH+FIFO_WIDTH-1 cycles. tile_done=1 only in the last cycle (t+FIFO_DEPTH+FIFO_WIDTH-1); the next cycle is FILL with count=0 and all valids low. drain_start during DRAIN is ignored.
- Latency of the first weight: 1 cycle after drain_start.
- No data reordering, no overflow possible (in_ready gates writes), no underflow (drain only from FULL).
- Lane skew is implemented as j register stages on lane j, on top of the shared depth storage.

Optional Feature:
- Macro WEIGHT_SKEW_FIFO_RECIRC_EN.
- Defined: each row popped in DRAIN is rewritten at the tail, preserving the tile. At DRAIN end the state returns to FULL with count=FIFO_DEPTH, so repeated drain_start replays the identical tile with identical timing. count stays FIFO_DEPTH throughout DRAIN. The only way to load a new tile is reset.
- Undefined: behaviour as above (tile consumed, return to FILL, count=0).

Test Plan:
- Reset: DATA_WIDTH=16, FIFO_WIDTH=4, FIFO_DEPTH=4; hold rstn=0 two cycles -> in_ready=1, count=0, out_valid=4'b0000, w_out all 0.
- Fill with backpressure-free stream: rows r=0..3, lane j value 16*r+j, in_valid every cycle -> count 1,2,3,4; in_ready low after the 4th accept; a 5th valid row is not accepted and count stays 4.
- Skewed drain: pulse drain_start at t -> lane 0 emits 0,16,32,48 at t+1..t+4; lane 3 emits 3,19,35,51 at t+4..t+7; tile_done at t+7 only; FILL, count=0 at t+8.
- Lane mask: accept row with lane_mask=4'b0101, w_in all 16'hABCD -> on drain, lanes 0 and 2 output 16'hABCD, lanes 1 and 3 output 0 with out_valid still 1.
- Reset mid-drain: rstn=0 at t+3 -> next cycle all valids 0, count=0, FILL state, no further outputs; a refill of 4 rows then drains correctly.
- RECIRC_EN build: fill 4 rows, drain twice -> both drains output identical sequences with identical timing; count=4 after each; in_ready stays 0.
